blk_mem_sdp: RTL
================

BLK_MEM_SDP -- requirements
Module: blk_mem_sdp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data word width in bits; a multiple of 8, minimum 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have local NB = DATA_WIDTH/8: byte lanes per word.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports named clka and rstn.
REQ-005 clka  input  1  clock; all state changes on its rising edge except reset.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  synchronous request to re-zero the whole array.
REQ-008 ena  input  1  write-port enable.
REQ-009 wea  input  NB  byte write enables; bit i covers dina[8i+7:8i].
REQ-010 addra  input  ADDR_WIDTH  write address.
REQ-011 dina  input  DATA_WIDTH  write data.
REQ-012 enb  input  1  read-port enable.
REQ-013 addrb  input  ADDR_WIDTH  read address.
REQ-014 doutb  output  DATA_WIDTH  read data.
REQ-015 validb  output  1  one-cycle pulse marking doutb as fresh read data.
REQ-016 busy  output  1  high while the clear engine owns the array.

Function
REQ-017 SHALL implement a simple dual-port array: one write port (A) and one read port (B), both on clka.
REQ-018 SHALL have a two-state FSM:
- CLEAR: writes zero to address cnt, then increments cnt; leaves for RUN on the edge that writes address 2**ADDR_WIDTH-1.
- RUN: services ports; clr=1 enters CLEAR with cnt=0 on the next edge.
REQ-019 SHALL drive busy=1 exactly while in CLEAR.
REQ-020 In CLEAR, SHALL ignore ena, enb and clr: no user write, no read, validb=0, doutb held.
REQ-021 In RUN with ena=1, SHALL write each byte lane whose wea bit is set and leave lanes with a clear bit unchanged; ena=1 with wea=0 writes nothing.
REQ-022 In RUN with enb=1 at edge t, SHALL present mem[addrb] on doutb with validb=1 after edge t+1 (latency 1), unless extended by REQ-031.
REQ-023 SHALL pulse validb for one cycle per accepted read; enb held high yields validb high on consecutive cycles.
REQ-024 SHALL hold doutb at its last value when no read completes.
REQ-025 Read/write collision (ena=1, enb=1, addra==addrb, same edge) SHALL be write-first: new dina bytes on lanes with wea set, old stored bytes on the other lanes.
REQ-026 clr=1 together with ena/enb in RUN: clr SHALL win; the write is dropped and the read is not accepted.
REQ-027 A read accepted on the edge before CLEAR is entered SHALL still complete with its validb pulse.
REQ-028 SHALL wrap cnt only via the CLEAR-to-RUN transition; it never overruns the array.

Reset
REQ-029 While rstn=0, SHALL force doutb=0, validb=0, busy=1, state=CLEAR, cnt=0; all pipeline registers SHALL be cleared.
REQ-030 The array SHALL NOT be reset asynchronously; it is zeroed by CLEAR, and busy falls after 2**ADDR_WIDTH clka edges following rstn release. Reset mid-CLEAR or mid-read SHALL restart CLEAR from cnt=0 and drop in-flight reads.

Configuration
REQ-031 With macro BLK_MEM_SDP_OUT_REG_EN defined, SHALL add a second output register so read latency is 2 (enb at edge t -> doutb/validb after edge t+2). Collision merge stays at stage 1. The added stage SHALL reset to 0.
REQ-032 Without BLK_MEM_SDP_OUT_REG_EN, read latency SHALL be exactly 1 with no additional stage.

Verification
REQ-033 Reset release, ADDR_WIDTH=4 -> busy=1 for 16 edges then 0; reads of addresses 0..15 return 0x00000000.
REQ-034 Write addra=5, dina=0xDEADBEEF, wea=4'b1111; then write dina=0x11223344, wea=4'b0101; read 5 -> doutb=0xDE22BE44, validb pulse at latency 1 (2 with the macro).
REQ-035 Same-edge write addra=addrb=7, dina=0xCAFEF00D, wea=4'b0011 over stored 0xAAAAAAAA -> doutb=0xAAAAF00D.
REQ-036 In RUN, clr=1 with ena=1 writing 0x12345678 to address 3 -> busy=1 next cycle; after CLEAR, read 3 returns 0.
REQ-037 Back-to-back reads of addresses 1,2,3 with enb held -> validb high 3 consecutive cycles with the matching data; enb low -> doutb holds the last value.
REQ-038 rstn pulsed low for 1 cycle mid-CLEAR at cnt=9 -> doutb=0 and validb=0 immediately; busy stays 1 for a full 16 edges after release.

Source files
------------

// File: rtl/blk_mem_sdp.sv
// Simple dual-port byte-write RAM with a self-clearing FSM. Read latency is 1, or 2 when BLK_MEM_SDP_OUT_REG_EN is defined.
// There is no backpressure: busy marks the clear sweep, and ports A and B are ignored while it is high.
module blk_mem_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clka,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      ena,
  input  logic [DATA_WIDTH/8-1:0]   wea,
  input  logic [ADDR_WIDTH-1:0]     addra,
  input  logic [DATA_WIDTH-1:0]     dina,
  input  logic                      enb,
  input  logic [ADDR_WIDTH-1:0]     addrb,
  output logic [DATA_WIDTH-1:0]     doutb,
  output logic                      validb,
  output logic                      busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_acc;
  logic                    rd_acc;
  logic [NB-1:0]           wr_be;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_dat;
  logic [DATA_WIDTH-1:0]   rd_old;
  logic [DATA_WIDTH-1:0]   rd_dat_d;

  logic [DATA_WIDTH-1:0]   dout1_q;
  logic                    vld1_q;

  // cnt_q returns to zero by its own wrap on the last clear write.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (clr) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = (state_q == S_CLEAR);

  // clr takes priority over both user ports on the same edge.
  always_comb begin
    wr_acc  = (state_q == S_RUN) && ena && !clr;
    rd_acc  = (state_q == S_RUN) && enb && !clr;
    wr_be   = '0;
    wr_addr = addra;
    wr_dat  = dina;
    if (state_q == S_CLEAR) begin
      wr_be   = '1;
      wr_addr = cnt_q;
      wr_dat  = '0;
    end else if (wr_acc) begin
      wr_be = wea;
    end
  end

  always_ff @(posedge clka) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  // Write-first on collision: written lanes take dina, the others keep stored bytes.
  always_comb begin
    rd_old   = mem[addrb];
    rd_dat_d = rd_old;
    for (int i = 0; i < NB; i++) begin
      if (wr_acc && (addra == addrb) && wea[i]) begin
        rd_dat_d[8*i +: 8] = dina[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      dout1_q <= '0;
      vld1_q  <= 1'b0;
    end else begin
      vld1_q <= rd_acc;
      if (rd_acc) begin
        dout1_q <= rd_dat_d;
      end
    end
  end

`ifdef BLK_MEM_SDP_OUT_REG_EN
  logic [DATA_WIDTH-1:0]   dout2_q;
  logic                    vld2_q;

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      dout2_q <= '0;
      vld2_q  <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) begin
        dout2_q <= dout1_q;
      end
    end
  end

  assign doutb  = dout2_q;
  assign validb = vld2_q;
`else
  assign doutb  = dout1_q;
  assign validb = vld1_q;
`endif

endmodule
